// File: rtl/present80_core.sv
// rtl/present80_core.sv - iterative PRESENT-80 block cipher, one round per clock
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   abort      (only with PRESENT80_ABORT_EN) cancel a running encryption
//   start      request encryption of key/plaintext (ignored while busy)
//   key        80-bit cipher key
//   plaintext  64-bit input block
//   busy       encryption in progress
//   done       one-cycle completion pulse
//   ciphertext 64-bit result, held until the next completion or reset
//
// Optional feature macro: PRESENT80_ABORT_EN adds the abort input.

module present80_core #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PRESENT80_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] plaintext,
  output logic        busy,
  output logic        done,
  output logic [63:0] ciphertext
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  fsm_t        fsm, fsm_nxt;
  logic [63:0] state;
  logic [79:0] keyreg;
  logic [4:0]  rc;

  logic        abort_req;
  logic        accept;
  logic        round_en;
  logic        last_round;

  logic [63:0] s_in, s_out, p_out;
  logic [79:0] key_rot, key_nxt;

`ifdef PRESENT80_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  // Round datapath: add round key, substitution layer, bit permutation.
  always_comb begin
    s_in  = state ^ keyreg[79:16];
    s_out = '0;
    p_out = '0;
    for (int i = 0; i < 16; i++) begin
      s_out[4*i +: 4] = sbox(s_in[4*i +: 4]);
    end
    for (int i = 0; i < 63; i++) begin
      p_out[(16*i) % 63] = s_out[i];
    end
    p_out[63] = s_out[63];
  end

  // Key schedule: rotate left by 61 (same as right by 19), S-box on the top
  // nibble, then fold the round counter into bits 19:15.
  always_comb begin
    key_rot           = {keyreg[18:0], keyreg[79:19]};
    key_nxt           = key_rot;
    key_nxt[79:76]    = sbox(key_rot[79:76]);
    key_nxt[19:15]    = key_rot[19:15] ^ rc;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // FSM next-state logic; abort wins over completion on the final round
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (start) fsm_nxt = RUN;
      RUN:  if (abort_req || (rc == LAST_RC)) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (fsm == RUN);
    accept     = (fsm == IDLE) && start;
    round_en   = (fsm == RUN) && !abort_req;
    last_round = round_en && (rc == LAST_RC);
  end

  // Datapath registers; the last round also applies the final whitening key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= '0;
      keyreg     <= '0;
      rc         <= '0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= plaintext;
        keyreg <= key;
        rc     <= 5'd1;
      end else if (round_en) begin
        state  <= p_out;
        keyreg <= key_nxt;
        if (last_round) begin
          ciphertext <= p_out ^ key_nxt[79:16];
          done       <= 1'b1;
        end else begin
          rc <= rc + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_present80_core.sv
// tb/tb_present80_core.sv - scoreboard testbench for present80_core

module tb_present80_core;

  localparam int ROUNDS = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key;
  logic [63:0] plaintext;
  logic        busy;
  logic        done;
  logic [63:0] ciphertext;
`ifdef PRESENT80_ABORT_EN
  logic        abort;
`endif

  present80_core #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PRESENT80_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] ct;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [79:0] K_ZERO = 80'h0;
  localparam logic [79:0] K_ONES = {80{1'b1}};
  localparam logic [63:0] P_ZERO = 64'h0;
  localparam logic [63:0] P_ONES = {64{1'b1}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; the expected result is queued if requested.
  task automatic issue(input logic [79:0] k, input logic [63:0] p,
                       input bit push, input logic [63:0] exp_ct);
    exp_t e;
    key       = k;
    plaintext = p;
    start     = 1'b1;
    step();
    start     = 1'b0;
    if (push) begin
      e.ct = exp_ct;
      e.c0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    check("done_timeout", 64'(done), 64'd1);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("ciphertext", ciphertext, e.ct);
          check("latency", 64'(cyc - e.c0), 64'(ROUNDS));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    rst       = 1'b1;
    start     = 1'b0;
    key       = '0;
    plaintext = '0;
`ifdef PRESENT80_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ct", ciphertext, 64'h0);

    // All-zero key and plaintext, then ciphertext must hold
    issue(K_ZERO, P_ZERO, 1'b1, 64'h5579C1387B228445);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done();
    step(); step(); step();
    check("ct_hold", ciphertext, 64'h5579C1387B228445);
    check("done_low_after", 64'(done), 64'd0);

    // Back-to-back: second start issued in the done cycle
    issue(K_ONES, P_ZERO, 1'b1, 64'hE72C46C0F5945049);
    wait_done();
    issue(K_ZERO, P_ONES, 1'b1, 64'hA112FFC72F68417B);
    wait_done();
    step();

    // Plaintext changed mid-run must not affect the result
    issue(K_ONES, P_ONES, 1'b1, 64'h3333DCD3213210D2);
    step(); step(); step(); step();
    plaintext = P_ZERO;
    key       = K_ZERO;
    wait_done();
    step();

    // start re-asserted mid-run is ignored; busy stays high throughout
    issue(K_ZERO, P_ZERO, 1'b1, 64'h5579C1387B228445);
    for (int k = 1; k <= ROUNDS; k++) begin
      start = (k == 10 || k == 20);
      step();
      check("busy_during_run", 64'(busy), (k < ROUNDS) ? 64'd1 : 64'd0);
    end
    start = 1'b0;
    step();
    check("no_queued_start", 64'(busy), 64'd0);

    // Reset mid-run discards the operation
    issue(K_ONES, P_ONES, 1'b0, 64'h0);
    repeat (14) step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ct", ciphertext, 64'h0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_rst", 64'(saw_done), 64'd0);
    check("rst_start_ignored", 64'(busy), 64'd0);
    issue(K_ZERO, P_ZERO, 1'b1, 64'h5579C1387B228445);
    wait_done();
    step();

`ifdef PRESENT80_ABORT_EN
    // Abort on the final round beats completion
    issue(K_ONES, P_ZERO, 1'b0, 64'h0);
    repeat (ROUNDS - 1) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ct", ciphertext, 64'h5579C1387B228445);
    step();
    check("abort_done_late", 64'(done), 64'd0);
    // Abort while idle has no effect on a following start
    abort = 1'b1;
    step();
    abort = 1'b0;
    issue(K_ONES, P_ZERO, 1'b1, 64'hE72C46C0F5945049);
    wait_done();
    step();
`endif

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/present80_core.md
PRESENT80_CORE -- requirements
Module: present80_core

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 31: number of PRESENT rounds, legal range 1..31; values outside that range are unsupported.
REQ-002 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1: request encryption of the current key and plaintext.
REQ-005 The block SHALL have port key, input, 80: cipher key; bits [79:48] come from KEY_1, [47:16] from KEY_0[31:0], and [15:0] are zero-extended by the upstream register block.
REQ-006 The block SHALL have port plaintext, input, 64: {PLAIN_1, PLAIN_0}.
REQ-007 The block SHALL have port busy, output, 1: an encryption is in progress.
REQ-008 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 The block SHALL have port ciphertext, output, 64: result, driving the CMOS_OUT_1/CMOS_OUT_0 registers.

Function
REQ-010 The block SHALL implement an FSM with states IDLE and RUN: IDLE->RUN on start; RUN->IDLE after round ROUNDS.
REQ-011 In IDLE, when start=1 at edge E0, the block SHALL capture state<=plaintext, keyreg<=key, rc<=1, busy<=1.
REQ-012 At each edge E1..E(ROUNDS) in RUN, the block SHALL perform one round: state<=P(S(state ^ keyreg[79:16])), then keyreg<=update(keyreg, rc), then rc<=rc+1.
REQ-013 The key update SHALL be: rotate keyreg left by 61; keyreg[79:76]<=S(keyreg[79:76]); keyreg[19:15]^=rc[4:0].
REQ-014 S SHALL be the PRESENT 4-bit S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, applied to all 16 nibbles.
REQ-015 P SHALL move bit i to bit 16*i mod 63 for i=0..62, with bit 63 fixed.
REQ-016 At edge E(ROUNDS), the block SHALL load ciphertext with the round output XOR the updated keyreg[79:16], set done<=1, set busy<=0, and enter IDLE.
REQ-017 done SHALL be high for exactly the one cycle following E(ROUNDS).
REQ-018 Latency SHALL be ROUNDS cycles from the start edge to done, i.e. 31 at the default.
REQ-019 ciphertext SHALL hold its value until the next completion or reset.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 start in the cycle where done=1 SHALL be accepted, since the FSM is in IDLE, giving back-to-back operation every ROUNDS+1 cycles.
REQ-022 key and plaintext SHALL be sampled only at the accepting edge; later changes SHALL have no effect on the running operation.
REQ-023 rc SHALL be 5 bits and SHALL never wrap, because the maximum ROUNDS is 31.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set FSM=IDLE, busy=0, done=0, ciphertext=0, state=0, keyreg=0 and rc=0.
REQ-025 rst SHALL have priority over start and over any round in progress; an operation interrupted mid-run SHALL be discarded with no done pulse.
REQ-026 start asserted on the edge where rst=1 SHALL be ignored.

Configuration
REQ-027 The block SHALL compile in an abort feature when macro PRESENT80_ABORT_EN is defined.
REQ-028 With PRESENT80_ABORT_EN defined, the block SHALL add a 1-bit input abort; abort=1 in RUN SHALL force IDLE and busy=0 at the next edge, with no done pulse and ciphertext unchanged.
REQ-029 With PRESENT80_ABORT_EN defined, abort SHALL win over completion when both occur at E(ROUNDS), and abort in IDLE SHALL have no effect.
REQ-030 With PRESENT80_ABORT_EN undefined, the abort port and its logic SHALL be absent and behaviour SHALL be as in REQ-010..REQ-026.

Verification
REQ-031 The bench SHALL cover: key=0, plaintext=0, start pulse -> done in the 32nd cycle after start, ciphertext=5579C1387B228445.
REQ-032 The bench SHALL cover: key=all-ones, plaintext=0 -> ciphertext=E72C46C0F5945049; then key=0, plaintext=all-ones -> A112FFC72F68417B.
REQ-033 The bench SHALL cover: key=all-ones, plaintext=all-ones, with plaintext changed to 0 at cycle 5 -> ciphertext=3333DCD3213210D2, showing input sampling.
REQ-034 The bench SHALL cover: start re-asserted at cycles 10 and 20 of a run -> exactly one done, at cycle 31, with busy continuously high meanwhile.
REQ-035 The bench SHALL cover: rst at cycle 15 of a run -> busy=0, done never asserted, ciphertext=0; a new start after reset -> correct result at latency 31.
REQ-036 The bench SHALL cover, with PRESENT80_ABORT_EN defined: abort at cycle 31 -> no done, ciphertext keeps its previous value, busy=0 on the next cycle.
